// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, FSM state type and byte-lane enables shared by the load-store unit.
package lsu_pkg;
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;
    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;
    typedef enum logic [0:0] {IDLE, WAIT} lsu_state_t;
endpackage

// File: rtl/lsu_load_extract.sv
// lsu_load_extract: selects the addressed byte/half of a memory word and sign/zero-extends it.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] rd
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        uns;
    always_comb begin
        b   = word[{off, 3'b000} +: 8];
        h   = off[1] ? word[31:16] : word[15:0];
        uns = size[2];
        // size[1] covers W and the reserved code 3, both treated as a full word
        rd  = size[1] ? word
            : size[0] ? {{16{h[15] & ~uns}}, h}
            : {{24{b[7] & ~uns}}, b};
    end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: two-state load-store unit; stalls the core for every data-memory access.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses with core_misalign_o.
module riscv_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_stall_o,
    output logic              core_misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    input  logic              mem_ready_i
);
    lsu_state_t  state_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        idle;
    logic        mis;
    logic [31:0] ext;

    assign idle = state_q == IDLE;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = rst_ni && idle && core_req_i &&
                 (core_size_i[1] ? core_addr_i[1:0] != 2'b00 : core_size_i[0] & core_addr_i[0]);
`else
    assign mis = 1'b0;
`endif

    lsu_load_extract u_extract (
        .size (size_q),
        .off  (off_q),
        .word (mem_rd_i),
        .rd   (ext)
    );

    always_comb begin
        core_stall_o    = !rst_ni ? core_req_i : idle ? core_req_i & ~mis : ~mem_ready_i;
        mem_req_o       = rst_ni & (idle ? core_req_i & ~mis : ~mem_ready_i);
        core_misalign_o = mis;
        mem_we_o        = core_we_i;
        mem_addr_o      = core_addr_i;
        mem_be_o        = core_size_i[1] ? BE_W
                        : core_size_i[0] ? BE_H << {core_addr_i[1], 1'b0}
                        : BE_B << core_addr_i[1:0];
        mem_wd_o        = core_size_i[1] ? core_wd_i
                        : core_size_i[0] ? {2{core_wd_i[15:0]}}
                        : {4{core_wd_i[7:0]}};
        core_rd_o       = (rst_ni && !idle && !core_we_i) ? ext : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            size_q  <= '0;
            off_q   <= '0;
        end else if (idle && core_req_i && !mis) begin
            state_q <= WAIT;
            size_q  <= core_size_i;
            off_q   <= core_addr_i[1:0];
        end else if (!idle && mem_ready_i) begin
            state_q <= IDLE;
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed scoreboard bench for riscv_lsu (works with or without LSU_MISALIGN_TRAP_EN).
module tb_riscv_lsu;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_wd_i = '0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = '0;
    logic        mem_ready_i = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] sb_q[$];

    riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_misalign_o(core_misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [1:0] a);
        case (sz[1:0])
            2'd0:    return 4'b0001 << a;
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] d);
        case (sz[1:0])
            2'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'd1:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] sz, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] s;
        if (sz[1]) return w;
        if (sz[0]) begin
            s = w >> (a[1] ? 16 : 0);
            return sz[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        end
        s = w >> (8 * a);
        return sz[2] ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    endfunction

    // one full access: issue, `waits` not-ready cycles, then completion
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdata, input int waits);
        logic [31:0] e;
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = a; core_wd_i = wd;
        mem_ready_i = 1'b0; mem_rd_i = 32'h0;
        sb_q.push_back(we ? 32'h0 : m_rd(sz, a[1:0], rdata));
        @(negedge clk_i);
        chk("issue_req", {31'h0, mem_req_o}, 32'h1);
        chk("issue_stall", {31'h0, core_stall_o}, 32'h1);
        chk("issue_we", {31'h0, mem_we_o}, {31'h0, we});
        chk("issue_be", {28'h0, mem_be_o}, {28'h0, m_be(sz, a[1:0])});
        chk("issue_addr", mem_addr_o, a);
        if (we) chk("issue_wd", mem_wd_o, m_wd(sz, wd));
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk_i); #1;
            mem_ready_i = (k == waits); mem_rd_i = rdata;
            @(negedge clk_i);
            chk("wait_stall", {31'h0, core_stall_o}, {31'h0, k != waits});
            chk("wait_req", {31'h0, mem_req_o}, {31'h0, k != waits});
            if (k == waits) begin
                e = sb_q.pop_front();
                chk("done_rd", core_rd_o, e);
            end
        end
    endtask

    task automatic idle_check();
        @(posedge clk_i); #1;
        core_req_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("idle_stall", {31'h0, core_stall_o}, 32'h0);
        chk("idle_req", {31'h0, mem_req_o}, 32'h0);
        chk("idle_rd", core_rd_o, 32'h0);
    endtask

    initial begin
        #2;
        chk("rst_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_stall", {31'h0, core_stall_o}, 32'h0);
        chk("rst_rd", core_rd_o, 32'h0);
        chk("rst_mis", {31'h0, core_misalign_o}, 32'h0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        idle_check();
        access(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0);
        access(1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 0);
        access(1'b0, 3'd0, 32'h101, 32'h0, 32'h0000F000, 0);
        access(1'b0, 3'd4, 32'h101, 32'h0, 32'h0000F000, 0);
        access(1'b0, 3'd5, 32'h102, 32'h0, 32'h80010000, 0);
        access(1'b0, 3'd1, 32'h100, 32'h0, 32'h00008123, 0);
        access(1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 3);
        idle_check();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] sz;
            logic [1:0] a;
            sz = 3'($urandom_range(0, 4));
            if (sz == 3'd3) sz = 3'd5;
            a = sz[1] ? 2'b00 : sz[0] ? {1'($urandom_range(0, 1)), 1'b0} : 2'($urandom_range(0, 3));
            access(1'b0, sz, {28'h0, 2'b01, a}, 32'h0, $urandom, $urandom_range(0, 2));
        end
        idle_check();
        // async reset while waiting on the memory
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h300;
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_req", {31'h0, mem_req_o}, 32'h0);
        chk("arst_stall", {31'h0, core_stall_o}, 32'h1);
        chk("arst_rd", core_rd_o, 32'h0);
        core_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_stall", {31'h0, core_stall_o}, 32'h0);
        chk("post_rst_req", {31'h0, mem_req_o}, 32'h0);
        access(1'b0, 3'd2, 32'h300, 32'h0, 32'h13572468, 0);
        idle_check();
`ifdef LSU_MISALIGN_TRAP_EN
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h102;
        @(negedge clk_i);
        chk("mis_flag", {31'h0, core_misalign_o}, 32'h1);
        chk("mis_req", {31'h0, mem_req_o}, 32'h0);
        chk("mis_stall", {31'h0, core_stall_o}, 32'h0);
        idle_check();
`else
        access(1'b0, 3'd2, 32'h102, 32'h0, 32'h89ABCDEF, 0);
        chk("mis_flag", {31'h0, core_misalign_o}, 32'h0);
        idle_check();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout: observed no finish expected finish");
    end
endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load-store unit between the core's data-memory port and the external data memory.
- Converts core load/store requests (address, size, sign) into word-addressed memory transactions with byte enables and lane-replicated write data.
- Extracts and sign/zero-extends load data returned by the memory one cycle after the request.
- Stalls the core for the duration of every access. The memory returns registered read data with ready.

Parameters:
- ADDR_W, 32: core/memory address width.
- DATA_W, 32: data width; the only supported value is 32.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- core_req_i  in  1  core requests an access; held stable while core_stall_o=1
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  lsu_pkg size code: B=0, H=1, W=2, BU=4, HU=5
- core_addr_i  in  ADDR_W  byte address
- core_wd_i  in  DATA_W  store data, right-aligned
- core_rd_o  out  DATA_W  extended load result, valid in the cycle stall drops on a load
- core_stall_o  out  1  core must hold PC/inputs
- core_misalign_o  out  1  misaligned-access flag; tied 0 unless LSU_MISALIGN_TRAP_EN
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_W  byte address, passed through from core_addr_i
- mem_wd_o  out  DATA_W  lane-replicated write data
- mem_rd_i  in  DATA_W  memory read data, registered, valid the cycle after the request
- mem_ready_i  in  1  memory ready/response

Behaviour:
- FSM states: IDLE, WAIT. Reset (rst_ni=0, async) forces IDLE and clears latched size/offset to 0.
- Combinational outputs under reset: mem_req_o=0, core_misalign_o=0, core_rd_o=0, core_stall_o=core_req_i.
- IDLE:
  - mem_req_o=core_req_i, core_stall_o=core_req_i.
  - On core_req_i: latch core_size_i and core_addr_i[1:0], go to WAIT.
- WAIT:
  - mem_ready_i=1: core_stall_o=0, mem_req_o=0, core_rd_o valid, next IDLE.
  - mem_ready_i=0: core_stall_o=1, mem_req_o=1 (re-issue), stay in WAIT.
- Latency: 2 cycles per access (1 stall cycle) with always-ready memory. Stores use the same sequence.
- Back-to-back: a new core_req_i in the cycle after WAIT completes is accepted from IDLE normally. No request is accepted while in WAIT.
- mem_we_o=core_we_i; mem_addr_o=core_addr_i; both are driven whenever mem_req_o=1.
- Width is size[1:0]; size[2]=unsigned. size[1:0]=3 is treated as W.
- Byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<{addr[1],1'b0}; W -> 4'b1111.
- Write data: B -> {4{wd[7:0]}}; H -> {2{wd[15:0]}}; W -> wd.
- Load extract uses the latched offset/size:
  - B/BU selects byte lane off[1:0].
  - H/HU selects the half at off[1].
  - W passes through.
  - Sign extension when size[2]=0, zero extension when size[2]=1.
- core_rd_o=0 for stores and in IDLE.
- Reset asserted mid-access: returns to IDLE immediately, no response; the core re-issues after reset.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - Misaligned accesses are detected in IDLE: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - On a misaligned core_req_i: mem_req_o=0, core_misalign_o=1 for that cycle, core_stall_o=0, FSM stays IDLE.
- Undefined:
  - core_misalign_o tied 0.
  - W ignores addr[1:0]; H ignores addr[0].
  - The access proceeds as aligned.

Decomposition:
- lsu_pkg: size codes LDST_B/H/W/BU/HU, the state enum lsu_state_t {IDLE, WAIT}, and byte-lane constants.
- One sub-module, lsu_load_extract (combinational): latched size/offset and the 32-bit memory word in, extended result out.
- The FSM, byte-enable and write-data generation live in riscv_lsu.

Test Plan:
- SW, addr=0x100, wd=0xDEADBEEF, ready=1 -> cycle0: mem_req=1, we=1, be=1111, wd=0xDEADBEEF, stall=1; cycle1: stall=0, FSM back to IDLE.
- SB, addr=0x103, wd=0x000000A5 -> be=1000, mem_wd=0xA5A5A5A5. SH, addr=0x102, wd=0x1234 -> be=1100, mem_wd=0x12341234.
- LB, addr=0x101, mem_rd=0x0000F000 next cycle -> core_rd=0xFFFFFFF0. Same access with LBU -> 0x000000F0. LHU, addr=0x102, mem_rd=0x8001_0000 -> 0x00008001.
- LW with mem_ready_i=0 for 3 cycles, then 1 -> stall held for 4 cycles, mem_req re-issued in each WAIT cycle, core_rd=mem_rd in the completion cycle.
- rst_ni dropped asynchronously while in WAIT -> immediately IDLE, mem_req=0. After release, a new LW completes in 2 cycles.
- Misalignment:
  - With LSU_MISALIGN_TRAP_EN: LW at 0x102 -> core_misalign_o=1, mem_req_o=0, stall=0.
  - Without the macro: the same request issues be=1111 and completes normally.
